// File: rtl/bingo_pkg.sv
// Shared board constants, FSM states and the line-to-cell map.
// Cells are numbered row-major 0..24; lines 0-4 are rows, 5-9 columns, 10 main diag, 11 anti-diag.
package bingo_pkg;

  localparam int NUM_W = 5;
  localparam int CELLS = 25;
  localparam int LINES = 12;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_READY,
    ST_SCAN,
    ST_COUNT,
    ST_DONE,
    ST_WON
  } state_t;

  function automatic logic [4:0] line_cell(input logic [3:0] ln, input logic [2:0] pos);
    int l;
    int p;
    int c;
    l = int'(ln);
    p = int'(pos);
    if (l < 5)       c = l * 5 + p;
    else if (l < 10) c = p * 5 + (l - 5);
    else if (l == 10) c = p * 6;
    else             c = (p + 1) * 4;
    return 5'(c);
  endfunction

endpackage

// File: rtl/bingo_line_check.sv
// Combinational "line full" test: all five cells of line line_i are circled.
// circle_i is MSB-first, so cell i lives at bit 24-i.
module bingo_line_check
  import bingo_pkg::*;
(
  input  logic [CELLS-1:0] circle_i,
  input  logic [3:0]       line_i,
  output logic             full_o
);

  always_comb begin
    full_o = 1'b1;
    for (int j = 0; j < 5; j++) begin
      full_o = full_o & circle_i[5'd24 - line_cell(line_i, 3'(j))];
    end
  end

endmodule

// File: rtl/bingo_board_ctrl.sv
// One player's 5x5 board: serial load, serial mark scan, 12-cycle line recount, sticky win.
// Define BINGO_MARK_ERR_EN to flag misses and repeat marks on err alongside mark_done.
module bingo_board_ctrl #(
  parameter int NUM_W     = bingo_pkg::NUM_W,
  parameter int WIN_LINES = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 new_game,
  input  logic                 load_valid,
  input  logic [NUM_W-1:0]     load_num,
  output logic                 load_ready,
  input  logic                 mark_valid,
  input  logic [NUM_W-1:0]     mark_num,
  output logic                 mark_ready,
  output logic [25*NUM_W-1:0]  map,
  output logic [24:0]          circle,
  output logic [3:0]           line_count,
  output logic                 win,
  output logic                 busy,
  output logic                 mark_done,
  output logic                 mark_hit,
  output logic                 err
);

  import bingo_pkg::*;

  state_t           state_q, state_d;
  logic [4:0]       idx_q;
  logic [NUM_W-1:0] cell_q [CELLS];
  logic [NUM_W-1:0] num_q;
  logic [CELLS-1:0] circle_q;
  logic             hit_q;
  logic [3:0]       line_q;
  logic [3:0]       acc_q;
  logic [3:0]       line_count_q;
  logic             win_q;
  logic             match;
  logic             line_full;
  logic [3:0]       acc_next;

  assign match    = (cell_q[idx_q] == num_q);
  assign acc_next = acc_q + {3'b000, line_full};

  bingo_line_check u_line_check (
    .circle_i (circle_q),
    .line_i   (line_q),
    .full_o   (line_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_LOAD;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (new_game) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD:  if (load_valid && idx_q == 5'd24) state_d = ST_READY;
        ST_READY: if (mark_valid) state_d = ST_SCAN;
        ST_SCAN: begin
          if (match)               state_d = ST_COUNT;
          else if (idx_q == 5'd24) state_d = ST_DONE;
        end
        ST_COUNT: if (line_q == 4'd11) state_d = ST_DONE;
        ST_DONE:  state_d = win_q ? ST_WON : ST_READY;
        ST_WON:   state_d = ST_WON;
        default:  state_d = ST_LOAD;
      endcase
    end
  end

  // The map survives new_game; only rst clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CELLS; i++) cell_q[i] <= '0;
      idx_q        <= '0;
      num_q        <= '0;
      circle_q     <= '0;
      hit_q        <= 1'b0;
      line_q       <= '0;
      acc_q        <= '0;
      line_count_q <= '0;
      win_q        <= 1'b0;
    end else if (new_game) begin
      idx_q        <= '0;
      circle_q     <= '0;
      hit_q        <= 1'b0;
      line_count_q <= '0;
      win_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (load_valid) begin
            cell_q[idx_q] <= load_num;
            idx_q         <= (idx_q == 5'd24) ? 5'd0 : idx_q + 5'd1;
          end
        end
        ST_READY: begin
          if (mark_valid) begin
            num_q <= mark_num;
            idx_q <= '0;
            hit_q <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (match) begin
            circle_q[5'd24 - idx_q] <= 1'b1;
            hit_q                   <= 1'b1;
            line_q                  <= '0;
            acc_q                   <= '0;
          end else if (idx_q != 5'd24) begin
            idx_q <= idx_q + 5'd1;
          end
        end
        ST_COUNT: begin
          acc_q  <= acc_next;
          line_q <= line_q + 4'd1;
          if (line_q == 4'd11) begin
            line_count_q <= acc_next;
            win_q        <= win_q | (int'(acc_next) >= WIN_LINES);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BINGO_MARK_ERR_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (new_game) begin
      err_q <= 1'b0;
    end else if (state_q == ST_READY && mark_valid) begin
      err_q <= 1'b0;
    end else if (state_q == ST_SCAN) begin
      if (match)               err_q <= circle_q[5'd24 - idx_q];
      else if (idx_q == 5'd24) err_q <= 1'b1;
    end
  end
`endif

  always_comb begin
    load_ready = (state_q == ST_LOAD);
    mark_ready = (state_q == ST_READY);
    busy       = (state_q == ST_SCAN) || (state_q == ST_COUNT) || (state_q == ST_DONE);
    mark_done  = (state_q == ST_DONE);
    mark_hit   = mark_done & hit_q;
`ifdef BINGO_MARK_ERR_EN
    err        = mark_done & err_q;
`else
    err        = 1'b0;
`endif
  end

  always_comb begin
    map = '0;
    for (int i = 0; i < CELLS; i++) begin
      map[25*NUM_W-1-NUM_W*i -: NUM_W] = cell_q[i];
    end
  end

  assign circle     = circle_q;
  assign line_count = line_count_q;
  assign win        = win_q;

endmodule
